boot_init_memory: RTL and testbench
===================================

Name: boot_init_memory

Overview:
- Parametrised, fully synchronous successor to the command memory. It holds program/command words for the controller.
- After reset it sweeps every location to zero and plants a configurable boot instruction, then serves single-cycle-latency reads and synchronous writes.
- Sits between the controller's address/command path and the datapath. It replaces the combinational, level-triggered store with a clocked, initialisation-aware block.

Parameters:
- DATA_W, 8, word width in bits.
- ADDR_W, 13, address width in bits.
- DEPTH, 8192, number of words; must satisfy 2 <= DEPTH <= 2**ADDR_W.
- BOOT_ADDR, 0, location loaded with BOOT_WORD during init; must be < DEPTH.
- BOOT_WORD, 8'hF9, boot instruction (LDI: opcode 111, addr-op 11, jump-op 00, 1).
- WRITE_FIRST, 1, read-during-write behaviour at the same address: 1 returns new data, 0 returns old data.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- address  in  ADDR_W  read/write address.
- write_data  in  DATA_W  write data.
- mem_write  in  1  write enable, sampled on clk.
- mem_read  in  1  read request, sampled on clk.
- command  out  DATA_W  registered read data.
- command_valid  out  1  one-cycle pulse, command updated this cycle.
- ready  out  1  high once init is complete; requests are accepted only while high.
- addr_err  out  1  one-cycle pulse for an accepted request with address >= DEPTH.

Behaviour:
- Reset (rst=0, async): state=INIT, init_cnt=0, command=0, command_valid=0, ready=0, addr_err=0. Array contents are not touched asynchronously.
- State INIT:
  - Each clk writes mem[init_cnt] = (init_cnt==BOOT_ADDR) ? BOOT_WORD : 0, then init_cnt++.
  - On the cycle writing init_cnt==DEPTH-1, next state=IDLE and ready<=1.
  - Init takes exactly DEPTH clocks after rst deasserts; ready is first seen high at the clk edge DEPTH after release.
  - mem_read and mem_write during INIT are ignored: no array change, no command_valid, no addr_err.
- State IDLE:
  - mem_write=1, address<DEPTH: mem[address]<=write_data at the edge.
  - mem_read=1, address<DEPTH: command<=mem[address] at the edge; command_valid=1 for that cycle. Latency is 1 clock.
  - mem_read=0: command holds its last value; command_valid=0.
  - Read and write together at the same address: command = write_data if WRITE_FIRST=1, else the prior contents.
  - Address >= DEPTH (only possible when DEPTH<2**ADDR_W):
    - write is dropped;
    - a read returns command=0 with command_valid=1;
    - addr_err pulses 1 cycle for any accepted request with a bad address.
  - write_data==0 is a legal write; the enable alone qualifies the write, not data value.
- Reset mid-INIT: the sweep restarts from 0.
- Reset in IDLE: all registered outputs clear immediately. After release the array is re-swept and user writes are lost.
- init_cnt is ADDR_W wide and never wraps past DEPTH-1. State encoding has two states; an illegal encoding recovers to INIT.
- No combinational path from inputs to any output.

Test Plan:
- DEPTH=16, ADDR_W=4. Release rst, hold mem_read=1 at address 0 throughout: ready rises after 16 clks, no command_valid before that; the first valid read returns command=8'hF9 and all other addresses read 0.
- After ready, write 8'hA5 to address 3, then read address 3 the next cycle: command=8'hA5 with command_valid pulse 1 cycle later. Reading address 4 returns 8'h00.
- Same-cycle mem_write=1 and mem_read=1 at address 5 with write_data=8'h3C (old 8'h00): WRITE_FIRST=1 gives 8'h3C; WRITE_FIRST=0 gives 8'h00, and a follow-up read gives 8'h3C.
- DEPTH=12, ADDR_W=4. Write 8'hFF to address 13, then read 13: addr_err pulses on both; command=0. Reading address 11 afterwards still gives its prior value.
- Assert rst low for 1 cycle at init_cnt=7, then again in IDLE after writing 8'h77 to address 2:
  - outputs clear asynchronously;
  - ready low for a full 16 clks;
  - address 2 reads 0 and address 0 reads 8'hF9.
- Write 8'h00 over the boot word at address 0 and read back: command=8'h00, confirming zero-data writes take effect.

Source files
------------

// File: rtl/boot_init_memory.sv
// Clocked command store for the controller: sweeps itself to zero with a boot word
// after reset, then serves registered single-cycle reads and synchronous writes.
module boot_init_memory #(
    parameter int                DATA_W      = 8,
    parameter int                ADDR_W      = 13,
    parameter int                DEPTH       = 8192,
    parameter int                BOOT_ADDR   = 0,
    parameter logic [DATA_W-1:0] BOOT_WORD   = 8'hF9,
    parameter bit                WRITE_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] write_data,
    input  logic              mem_write,
    input  logic              mem_read,
    output logic [DATA_W-1:0] command,
    output logic              command_valid,
    output logic              ready,
    output logic              addr_err
);

    // Handshake: a request (mem_read/mem_write) is accepted only on an edge where
    // ready was high; an accepted read raises command_valid for exactly the next cycle.
    localparam logic [1:0] ST_INIT = 2'b01;
    localparam logic [1:0] ST_IDLE = 2'b10;

    localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] BOOT_A    = ADDR_W'(BOOT_ADDR);

    logic [1:0]        state;
    logic [ADDR_W-1:0] init_cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              in_range;
    logic              accept;

    assign in_range = ({1'b0, address} < DEPTH_W);
    assign accept   = (state == ST_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_INIT;
            init_cnt <= '0;
            ready    <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    // Counter parks on the last location instead of wrapping.
                    if (init_cnt == LAST_ADDR) begin
                        state <= ST_IDLE;
                        ready <= 1'b1;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                ST_IDLE: ;
                default: begin
                    state    <= ST_INIT;
                    init_cnt <= '0;
                    ready    <= 1'b0;
                end
            endcase
        end
    end

    // Array has no reset; the sweep rewrites every location after each reset.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[init_cnt] <= (init_cnt == BOOT_A) ? BOOT_WORD : '0;
        end else if (accept && mem_write && in_range) begin
            mem[address] <= write_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            command       <= '0;
            command_valid <= 1'b0;
            addr_err      <= 1'b0;
        end else if (accept) begin
            command_valid <= mem_read;
            addr_err      <= (mem_read | mem_write) & ~in_range;
            if (mem_read) begin
                if (!in_range)
                    command <= '0;
                else if (WRITE_FIRST && mem_write)
                    command <= write_data;
                else
                    command <= mem[address];
            end
        end else begin
            command_valid <= 1'b0;
            addr_err      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_boot_init_memory.sv
// Bench for boot_init_memory: a 16-deep write-first and a 12-deep read-first instance
// share one stimulus stream and are each checked against a per-instance memory model.
module tb_boot_init_memory;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] address = '0;
    logic [7:0] write_data = '0;
    logic       mem_write = 1'b0;
    logic       mem_read = 1'b0;

    logic [7:0] cmd_a, cmd_b;
    logic       valid_a, valid_b, ready_a, ready_b, err_a, err_b;

    int vectors = 0;
    int errors = 0;

    // Reference model state, index 0 = 16-deep write-first, 1 = 12-deep read-first.
    int         depth_m [2] = '{16, 12};
    bit         wf_m    [2] = '{1'b1, 1'b0};
    logic [7:0] mem_m   [2][16];
    int         rel_cnt [2];
    logic [7:0] cmd_m   [2];
    bit         valid_m [2];
    bit         err_m   [2];
    bit         rdy_m   [2];

    always #5 clk = ~clk;

    boot_init_memory #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .BOOT_ADDR(0),
                       .BOOT_WORD(8'hF9), .WRITE_FIRST(1'b1)) dut_a (
        .clk(clk), .rst(rst), .address(address), .write_data(write_data),
        .mem_write(mem_write), .mem_read(mem_read), .command(cmd_a),
        .command_valid(valid_a), .ready(ready_a), .addr_err(err_a));

    boot_init_memory #(.DATA_W(8), .ADDR_W(4), .DEPTH(12), .BOOT_ADDR(0),
                       .BOOT_WORD(8'hF9), .WRITE_FIRST(1'b0)) dut_b (
        .clk(clk), .rst(rst), .address(address), .write_data(write_data),
        .mem_write(mem_write), .mem_read(mem_read), .command(cmd_b),
        .command_valid(valid_b), .ready(ready_b), .addr_err(err_b));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) mem_m[d][i] = 8'h00;
            mem_m[d][0] = 8'hF9;
            rel_cnt[d]  = 0;
            cmd_m[d]    = 8'h00;
            valid_m[d]  = 1'b0;
            err_m[d]    = 1'b0;
            rdy_m[d]    = 1'b0;
        end
    endtask

    // Advance the model by one rising edge using the inputs present before the edge.
    task automatic model_edge();
        bit inr;
        for (int d = 0; d < 2; d++) begin
            if (!rdy_m[d]) begin
                valid_m[d] = 1'b0;
                err_m[d]   = 1'b0;
                rel_cnt[d]++;
                if (rel_cnt[d] == depth_m[d]) rdy_m[d] = 1'b1;
            end else begin
                inr        = (int'(address) < depth_m[d]);
                valid_m[d] = mem_read;
                err_m[d]   = (mem_read || mem_write) && !inr;
                if (mem_read) begin
                    if (!inr)                       cmd_m[d] = 8'h00;
                    else if (mem_write && wf_m[d])  cmd_m[d] = write_data;
                    else                            cmd_m[d] = mem_m[d][address];
                end
                if (mem_write && inr) mem_m[d][address] = write_data;
            end
        end
    endtask

    task automatic compare_all(input string where);
        check({where, " d16 command"}, 32'(cmd_a),   32'(cmd_m[0]));
        check({where, " d16 valid"},   32'(valid_a), 32'(valid_m[0]));
        check({where, " d16 ready"},   32'(ready_a), 32'(rdy_m[0]));
        check({where, " d16 addr_err"}, 32'(err_a),  32'(err_m[0]));
        check({where, " d12 command"}, 32'(cmd_b),   32'(cmd_m[1]));
        check({where, " d12 valid"},   32'(valid_b), 32'(valid_m[1]));
        check({where, " d12 ready"},   32'(ready_b), 32'(rdy_m[1]));
        check({where, " d12 addr_err"}, 32'(err_b),  32'(err_m[1]));
    endtask

    task automatic cycle(input string where);
        if (rst) model_edge();
        @(posedge clk);
        #1;
        compare_all(where);
    endtask

    task automatic drive(input bit rd, input bit wr, input logic [3:0] a, input logic [7:0] wd);
        mem_read   = rd;
        mem_write  = wr;
        address    = a;
        write_data = wd;
    endtask

    // Pulls rst low away from the edge, checks the asynchronous clear, holds one edge.
    task automatic pulse_reset(input string where);
        rst = 1'b0;
        #1;
        model_reset();
        compare_all({where, " async"});
        cycle({where, " held"});
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        #1;
        compare_all("power-on");
        cycle("reset edge");
        rst = 1'b1;

        // Reads at address 0 during init must be ignored; abort the sweep part way.
        drive(1'b1, 1'b0, 4'd0, 8'h00);
        for (int i = 0; i < 7; i++) cycle("init part");
        pulse_reset("mid-init reset");
        for (int i = 0; i < 18; i++) cycle("init read0");

        for (int a = 0; a < 16; a++) begin
            drive(1'b1, 1'b0, 4'(a), 8'h00);
            cycle("sweep read");
        end

        drive(1'b0, 1'b1, 4'd3, 8'hA5); cycle("write a5");
        drive(1'b1, 1'b0, 4'd3, 8'h00); cycle("read 3");
        drive(1'b1, 1'b0, 4'd4, 8'h00); cycle("read 4");
        drive(1'b0, 1'b0, 4'd4, 8'h00); cycle("idle hold");

        drive(1'b1, 1'b1, 4'd5, 8'h3C); cycle("rw same 5");
        drive(1'b1, 1'b0, 4'd5, 8'h00); cycle("reread 5");

        drive(1'b0, 1'b1, 4'd11, 8'h5A); cycle("write 11");
        drive(1'b0, 1'b1, 4'd13, 8'hFF); cycle("write 13");
        drive(1'b1, 1'b0, 4'd13, 8'h00); cycle("read 13");
        drive(1'b1, 1'b0, 4'd11, 8'h00); cycle("read 11");

        drive(1'b0, 1'b1, 4'd2, 8'h77); cycle("write 77");
        drive(1'b0, 1'b0, 4'd0, 8'h00);
        pulse_reset("idle reset");
        drive(1'b1, 1'b0, 4'd2, 8'h00);
        for (int i = 0; i < 17; i++) cycle("re-init");
        drive(1'b1, 1'b0, 4'd0, 8'h00); cycle("boot after reinit");

        drive(1'b0, 1'b1, 4'd0, 8'h00); cycle("zero write");
        drive(1'b1, 1'b0, 4'd0, 8'h00); cycle("zero readback");

        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
            cycle("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
